result_streamer: RTL



---
 rtl/result_streamer_pkg.sv | 88 ++++++++
 rtl/result_streamer_bank.sv | 86 ++++++++
 rtl/result_streamer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/result_streamer_pkg.sv
// Shared constants, slot numbering and the symmetric index map for the
// result streamer and its ping-pong result banks.
package result_streamer_pkg;

  localparam logic [2:0] SEL1_B12 = 3'd0;
  localparam logic [2:0] SEL1_B13 = 3'd1;
  localparam logic [2:0] SEL1_B14 = 3'd2;
  localparam logic [2:0] SEL1_B23 = 3'd3;
  localparam logic [2:0] SEL1_B34 = 3'd4;
  localparam logic [2:0] SEL2_B11 = 3'd0;
  localparam logic [2:0] SEL2_B22 = 3'd1;
  localparam logic [2:0] SEL2_B33 = 3'd2;
  localparam logic [2:0] SEL2_B44 = 3'd3;
  localparam logic [2:0] SEL2_B24 = 3'd4;
  localparam logic [2:0] SEL_MAX  = 3'd4;
  localparam logic [2:0] NO_WRITE = 3'd7;

  localparam int unsigned NUM_SLOTS = 10;

  // Bank slot numbering: MAC1 entries occupy slots 0..4, MAC2 entries 5..9.
  localparam logic [3:0] SLOT_B12 = 4'd0;
  localparam logic [3:0] SLOT_B13 = 4'd1;
  localparam logic [3:0] SLOT_B14 = 4'd2;
  localparam logic [3:0] SLOT_B23 = 4'd3;
  localparam logic [3:0] SLOT_B34 = 4'd4;
  localparam logic [3:0] SLOT_B11 = 4'd5;
  localparam logic [3:0] SLOT_B22 = 4'd6;
  localparam logic [3:0] SLOT_B33 = 4'd7;
  localparam logic [3:0] SLOT_B44 = 4'd8;
  localparam logic [3:0] SLOT_B24 = 4'd9;

  localparam logic [3:0] IDX_FIRST = 4'd0;
  localparam logic [3:0] IDX_LAST  = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  function automatic logic [3:0] mac1_slot(input logic [2:0] sel);
    case (sel)
      SEL1_B12: return SLOT_B12;
      SEL1_B13: return SLOT_B13;
      SEL1_B14: return SLOT_B14;
      SEL1_B23: return SLOT_B23;
      SEL1_B34: return SLOT_B34;
      default:  return SLOT_B12;
    endcase
  endfunction

  function automatic logic [3:0] mac2_slot(input logic [2:0] sel);
    case (sel)
      SEL2_B11: return SLOT_B11;
      SEL2_B22: return SLOT_B22;
      SEL2_B33: return SLOT_B33;
      SEL2_B44: return SLOT_B44;
      SEL2_B24: return SLOT_B24;
      default:  return SLOT_B11;
    endcase
  endfunction

  // Row-major index (row*4+col) to bank slot; lower triangle mirrors upper.
  function automatic logic [3:0] sym_slot(input logic [3:0] idx);
    logic [1:0] lo;
    logic [1:0] hi;
    if (idx[3:2] <= idx[1:0]) begin
      lo = idx[3:2];
      hi = idx[1:0];
    end else begin
      lo = idx[1:0];
      hi = idx[3:2];
    end
    case ({lo, hi})
      4'b0000: return SLOT_B11;
      4'b0001: return SLOT_B12;
      4'b0010: return SLOT_B13;
      4'b0011: return SLOT_B14;
      4'b0101: return SLOT_B22;
      4'b0110: return SLOT_B23;
      4'b0111: return SLOT_B24;
      4'b1010: return SLOT_B33;
      4'b1011: return SLOT_B34;
      4'b1111: return SLOT_B44;
      default: return SLOT_B11;
    endcase
  endfunction

endpackage

// File: rtl/result_streamer_bank.sv
// One ping-pong bank: ten saturated entries, a fill mask and a full flag.
// Completion (mask reaching all-ones) sets full and clears the mask in one edge.
module result_bank
  import result_streamer_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             clr_mask_i,
  input  logic             wa_en_i,
  input  logic [3:0]       wa_slot_i,
  input  logic [OUT_W-1:0] wa_data_i,
  input  logic             wb_en_i,
  input  logic [3:0]       wb_slot_i,
  input  logic [OUT_W-1:0] wb_data_i,
  input  logic             clr_full_i,
  input  logic [3:0]       rd_slot_i,
  output logic [OUT_W-1:0] rd_data_o,
  output logic             full_o,
  output logic             complete_o
);

  logic [OUT_W-1:0]     mem_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] mask_q;
  logic [NUM_SLOTS-1:0] mask_d;
  logic [NUM_SLOTS-1:0] wbits_s;
  logic                 full_q;
  logic                 full_d;
  logic                 complete_s;

  // Mask / full next-state from this cycle's accepted writes.
  always_comb begin
    wbits_s = {NUM_SLOTS{1'b0}};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if ((wa_en_i && (wa_slot_i == 4'(k))) || (wb_en_i && (wb_slot_i == 4'(k)))) begin
        wbits_s[k] = 1'b1;
      end else begin
        wbits_s[k] = 1'b0;
      end
    end
    complete_s = (wa_en_i | wb_en_i) & (&(mask_q | wbits_s));
    if (clr_mask_i || complete_s) begin
      mask_d = {NUM_SLOTS{1'b0}};
    end else begin
      mask_d = mask_q | wbits_s;
    end
    full_d = (full_q & ~clr_full_i) | complete_s;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      mask_q <= {NUM_SLOTS{1'b0}};
      full_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      full_q <= full_d;
    end
  end

  // Entry storage; the two ports never target the same slot.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) mem_q[k] <= {OUT_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (wa_en_i && (wa_slot_i == 4'(k))) mem_q[k] <= wa_data_i;
        else if (wb_en_i && (wb_slot_i == 4'(k))) mem_q[k] <= wb_data_i;
        else mem_q[k] <= mem_q[k];
      end
    end
  end

  // Read port.
  always_comb begin
    rd_data_o = {OUT_W{1'b0}};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      rd_data_o = (rd_slot_i == 4'(k)) ? mem_q[k] : rd_data_o;
    end
  end

  assign full_o     = full_q;
  assign complete_o = complete_s;

endmodule

// File: rtl/result_streamer.sv
// Captures the 10 unique results of a symmetric 4x4 product into ping-pong
// banks and streams the full 16-entry matrix row-major over valid/ready.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             cf_load,
  input  logic [ACC_W-1:0] mac1_data,
  input  logic [2:0]       mac1_output_sel,
  input  logic [ACC_W-1:0] mac2_data,
  input  logic [2:0]       mac2_output_sel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [3:0]       out_index,
  output logic             out_last,
  output logic             overrun,
  output logic             busy
);

  function automatic logic [OUT_W-1:0] sat_val(input logic [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] hi;
    hi = v[ACC_W-1:OUT_W-1];
    if ((hi == {(ACC_W-OUT_W+1){1'b0}}) || (hi == {(ACC_W-OUT_W+1){1'b1}})) begin
      return v[OUT_W-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  stream_state_e    state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [3:0]       index_q, index_d;
  logic [3:0]       idx_d;
  logic             last_q, last_d;
  logic             overrun_q, overrun_d;

  logic [1:0]       full_s;
  logic [1:0]       complete_s;
  logic [1:0]       free_s;
  logic [OUT_W-1:0] rd_data_s [2];
  logic             m1_req_s, m2_req_s, m1_en_s, m2_en_s, blocked_s;
  logic [3:0]       rd_slot_s;

  // Capture gating: a bank freed this very edge may accept writes.
  always_comb begin
    m1_req_s  = (mac1_output_sel != NO_WRITE) && (mac1_output_sel <= SEL_MAX);
    m2_req_s  = (mac2_output_sel != NO_WRITE) && (mac2_output_sel <= SEL_MAX);
    blocked_s = full_s[wr_bank_q] & ~free_s[wr_bank_q];
    m1_en_s   = m1_req_s & ~cf_load & ~blocked_s;
    m2_en_s   = m2_req_s & ~cf_load & ~blocked_s;
    overrun_d = overrun_q | ((m1_req_s | m2_req_s) & ~cf_load & blocked_s);
    if (complete_s[wr_bank_q]) begin
      wr_bank_d = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    result_bank #(.OUT_W(OUT_W)) u_bank (
      .clk        (clk),
      .aclr_n     (aclr_n),
      .clr_mask_i (cf_load & (wr_bank_q == 1'(g))),
      .wa_en_i    (m1_en_s & (wr_bank_q == 1'(g))),
      .wa_slot_i  (mac1_slot(mac1_output_sel)),
      .wa_data_i  (sat_val(mac1_data)),
      .wb_en_i    (m2_en_s & (wr_bank_q == 1'(g))),
      .wb_slot_i  (mac2_slot(mac2_output_sel)),
      .wb_data_i  (sat_val(mac2_data)),
      .clr_full_i (free_s[g]),
      .rd_slot_i  (rd_slot_s),
      .rd_data_o  (rd_data_s[g]),
      .full_o     (full_s[g]),
      .complete_o (complete_s[g])
    );
  end

  // Stream FSM next state; index_q doubles as the stream position.
  always_comb begin
    state_d   = state_q;
    idx_d     = index_q;
    rd_bank_d = rd_bank_q;
    free_s    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (full_s[rd_bank_q]) begin
          state_d = ST_STREAM;
          idx_d   = IDX_FIRST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (valid_q && out_ready) begin
          if (index_q == IDX_LAST) begin
            free_s[rd_bank_q] = 1'b1;
            rd_bank_d         = ~rd_bank_q;
            idx_d             = IDX_FIRST;
            state_d           = full_s[~rd_bank_q] ? ST_STREAM : ST_IDLE;
          end else begin
            idx_d = index_q + 4'd1;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_FIRST;
      end
    endcase
    rd_slot_s = sym_slot(idx_d);
  end

  // Output word for the next cycle, zeroed while idle.
  always_comb begin
    valid_d = (state_d == ST_STREAM);
    if (valid_d) begin
      data_d  = rd_data_s[rd_bank_d];
      index_d = idx_d;
      last_d  = (idx_d == IDX_LAST);
    end else begin
      data_d  = {OUT_W{1'b0}};
      index_d = IDX_FIRST;
      last_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= ST_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= {OUT_W{1'b0}};
      index_q   <= IDX_FIRST;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      index_q   <= index_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign overrun   = overrun_q;
  assign busy      = full_s[0] | full_s[1];

endmodule
